// File: rtl/axil2reg_rd_pipe.sv
// Pipelined AXI4-Lite read channel to register-interface bridge.
// Up to DEPTH reads outstanding, fixed-latency register file, in-order responses.
module axil2reg_rd_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_okay
);
    localparam int ALIGN_BITS = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int WORD_W     = DATA_WIDTH + 2;

    generate
        if (RD_LATENCY < 1) begin : g_bad_latency
            $error("axil2reg_rd_pipe: RD_LATENCY must be >= 1");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("axil2reg_rd_pipe: DEPTH must be a power of 2 and >= 2");
        end
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("axil2reg_rd_pipe: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    logic                  unused_arprot;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  accept;
    logic                  aligned;
    logic                  pop;
    logic [RD_LATENCY-1:0] vld_pipe_reg;
    logic [RD_LATENCY-1:0] vld_pipe_next;
    logic [RD_LATENCY-1:0] bad_pipe_reg;
    logic [RD_LATENCY-1:0] bad_pipe_next;
    logic                  wr_en;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      body_cnt_reg;
    logic                  body_empty;
    logic                  head_direct;
    logic                  body_push;
    logic                  body_pop;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    assign unused_arprot  = ^s_axil_arprot;

    // Credits are taken at accept, so the response storage can never overflow.
    assign s_axil_arready = (cnt_reg < CNT_W'(DEPTH)) && !rst;
    assign accept         = s_axil_arvalid && s_axil_arready;
    assign aligned        = (s_axil_araddr[ALIGN_BITS-1:0] == '0);
    assign reg_rd_en      = accept && aligned;
    assign reg_rd_addr    = s_axil_araddr;

    assign vld_pipe_next[0] = accept;
    assign bad_pipe_next[0] = accept && !aligned;
    genvar gi;
    generate
        for (gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
            assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
            assign bad_pipe_next[gi] = bad_pipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_reg <= '0;
            bad_pipe_reg <= '0;
        end else begin
            vld_pipe_reg <= vld_pipe_next;
            bad_pipe_reg <= bad_pipe_next;
        end
    end

    assign wr_en   = vld_pipe_reg[RD_LATENCY-1];
    assign wr_word = bad_pipe_reg[RD_LATENCY-1] ? {{DATA_WIDTH{1'b0}}, 2'b10}
                                                : {reg_rd_data, (reg_rd_okay ? 2'b00 : 2'b10)};

    // The head register holds the oldest response; the body queue only fills behind it.
    assign pop         = rvalid_reg && s_axil_rready;
    assign body_empty  = (body_cnt_reg == '0);
    assign head_direct = wr_en && (!rvalid_reg || (pop && body_empty));
    assign body_push   = wr_en && !head_direct;
    assign body_pop    = pop && !body_empty;

    always_ff @(posedge clk) begin
        if (body_push) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            body_cnt_reg <= '0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= 2'b00;
        end else begin
            if (body_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (body_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (body_push && !body_pop) begin
                body_cnt_reg <= body_cnt_reg + CNT_W'(1);
            end else if (body_pop && !body_push) begin
                body_cnt_reg <= body_cnt_reg - CNT_W'(1);
            end

            if (body_pop) begin
                {rdata_reg, rresp_reg} <= mem[rd_ptr_reg];
                rvalid_reg             <= 1'b1;
            end else if (head_direct) begin
                {rdata_reg, rresp_reg} <= wr_word;
                rvalid_reg             <= 1'b1;
            end else if (pop) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (accept && !pop) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (pop && !accept) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign s_axil_rvalid = rvalid_reg;
    assign s_axil_rdata  = rdata_reg;
    assign s_axil_rresp  = rresp_reg;

endmodule

// File: tb/tb_axil2reg_rd_pipe.sv
// Bench for axil2reg_rd_pipe: vector table, scoreboard and multi-cycle sequences.
module tb_axil2reg_rd_pipe;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] s_axil_araddr = '0;
    logic [2:0]    s_axil_arprot = 3'b000;
    logic          s_axil_arvalid = 1'b0;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready = 1'b0;
    logic [AW-1:0] reg_rd_addr;
    logic          reg_rd_en;
    logic [DW-1:0] reg_rd_data;
    logic          reg_rd_okay;

    always #5 clk = ~clk;

    axil2reg_rd_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data), .reg_rd_okay(reg_rd_okay)
    );

    // Register file model: data = addr + 0x100, two-cycle latency, garbage when idle.
    logic [AW-1:0] fail_addr = 32'hFFFF_FFFF;
    logic [DW-1:0] d1_reg, d2_reg;
    logic          k1_reg, k2_reg;
    always @(posedge clk) begin
        d1_reg <= reg_rd_en ? reg_rd_addr + 32'h100 : 32'hA5A5_A5A5;
        k1_reg <= reg_rd_en ? (reg_rd_addr != fail_addr) : 1'b1;
        d2_reg <= d1_reg;
        k2_reg <= k1_reg;
    end
    assign reg_rd_data = d2_reg;
    assign reg_rd_okay = k2_reg;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;
    exp_t sb_q[$];

    int            cnt_model = 0;
    int            cyc = 0;
    int            acc_total = 0, pop_total = 0;
    int            acc_mark = 0, pop_mark = 0;
    int            first_acc_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic [1:0]    held_resp;

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic exp_ready, al, acc, pop;
        exp_t e, got;
        cyc++;
        if (rst) begin
            check("arready_in_reset", s_axil_arready, 0);
            check("rvalid_in_reset", s_axil_rvalid, 0);
            sb_q.delete();
            cnt_model = 0;
            hold_prev = 1'b0;
        end else begin
            exp_ready = (cnt_model < DEPTH);
            al  = (s_axil_araddr[1:0] == 2'b00);
            acc = s_axil_arvalid && exp_ready;
            pop = s_axil_rvalid && s_axil_rready;
            check("arready", s_axil_arready, exp_ready);
            check("reg_rd_en", reg_rd_en, acc && al);
            if (reg_rd_en) check("reg_rd_addr", reg_rd_addr, s_axil_araddr);
            if (hold_prev) begin
                check("hold_rvalid", s_axil_rvalid, 1);
                check("hold_rdata", s_axil_rdata, held_data);
                check("hold_rresp", s_axil_rresp, held_resp);
            end
            if (acc) begin
                e.data = al ? s_axil_araddr + 32'h100 : 32'h0;
                e.resp = (al && s_axil_araddr != fail_addr) ? 2'b00 : 2'b10;
                sb_q.push_back(e);
                if (acc_total == acc_mark) first_acc_cyc = cyc;
                acc_total++;
            end
            if (pop) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_response: got rdata 0x%0h with nothing outstanding, required none",
                             s_axil_rdata);
                end else begin
                    e = sb_q.pop_front();
                    got.data = s_axil_rdata;
                    got.resp = s_axil_rresp;
                    check("sb_rdata", got.data, e.data);
                    check("sb_rresp", got.resp, e.resp);
                end
                if (pop_total == pop_mark) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_total++;
            end
            cnt_model = cnt_model + (acc ? 1 : 0) - (pop ? 1 : 0);
            hold_prev = s_axil_rvalid && !s_axil_rready;
            held_data = s_axil_rdata;
            held_resp = s_axil_rresp;
        end
    end

    // rmode: 0 = rready high, 1 = random rready, 2 = rready low.
    task automatic drive_reads(input logic [AW-1:0] addrs[$], input int rmode,
                               output int stalls, output int sent);
        int guard;
        guard = 0; stalls = 0; sent = 0;
        @(posedge clk); #1;
        while (sent < addrs.size() && guard < 500) begin
            s_axil_araddr  = addrs[sent];
            s_axil_arvalid = 1'b1;
            s_axil_rready  = (rmode == 1) ? 1'($urandom_range(0, 1)) : (rmode == 0);
            @(negedge clk);
            guard++;
            if (s_axil_arready) sent++; else stalls++;
            @(posedge clk); #1;
        end
        s_axil_arvalid = 1'b0;
        s_axil_rready  = (rmode != 2);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        s_axil_rready = 1'b1;
        while (sb_q.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, sb_q.size(), 0);
        check({name, "_rvalid_idle"}, s_axil_rvalid, 0);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          fail;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_resp;
        logic          exp_en;
    } vec_t;

    initial begin
        vec_t          vecs[6];
        logic [AW-1:0] q[$];
        int            stalls, sent, lat, acc_n, r;

        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0000_0110, 2'b00, 1'b1};
        vecs[1] = '{32'h0000_0006, 1'b0, 32'h0000_0000, 2'b10, 1'b0};
        vecs[2] = '{32'h0000_0008, 1'b1, 32'h0000_0108, 2'b10, 1'b1};
        vecs[3] = '{32'h0000_03FC, 1'b0, 32'h0000_04FC, 2'b00, 1'b1};
        vecs[4] = '{32'h0000_0001, 1'b0, 32'h0000_0000, 2'b10, 1'b0};
        vecs[5] = '{32'hFFFF_FFF0, 1'b0, 32'h0000_00F0, 2'b00, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_arready", s_axil_arready, 0);
        check("rst_rvalid", s_axil_rvalid, 0);
        check("rst_rresp", s_axil_rresp, 0);
        check("rst_rdata", s_axil_rdata, 0);
        check("rst_reg_rd_en", reg_rd_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_arready", s_axil_arready, 1);

        // Isolated reads from the vector table
        for (int i = 0; i < 6; i++) begin
            fail_addr = vecs[i].fail ? vecs[i].addr : 32'hFFFF_FFFF;
            @(posedge clk); #1;
            s_axil_araddr  = vecs[i].addr;
            s_axil_arvalid = 1'b1;
            s_axil_rready  = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_arready", i), s_axil_arready, 1);
            check($sformatf("vec%0d_reg_rd_en", i), reg_rd_en, vecs[i].exp_en);
            @(posedge clk); #1;
            s_axil_arvalid = 1'b0;
            lat = 0;
            for (int c = 1; c <= 8 && lat == 0; c++) begin
                @(negedge clk);
                if (s_axil_rvalid) lat = c;
                else @(posedge clk);
            end
            check($sformatf("vec%0d_latency", i), lat, LAT + 1);
            check($sformatf("vec%0d_rdata", i), s_axil_rdata, vecs[i].exp_data);
            check($sformatf("vec%0d_rresp", i), s_axil_rresp, vecs[i].exp_resp);
            $display("vec %0d: addr 0x%08h rdata 0x%08h rresp %0b latency %0d",
                     i, vecs[i].addr, s_axil_rdata, s_axil_rresp, lat);
        end
        fail_addr = 32'hFFFF_FFFF;
        drain("vec");

        // Back-to-back burst of 8 with rready high
        q.delete();
        for (int k = 0; k < 8; k++) q.push_back(32'(k * 4));
        acc_mark = acc_total; pop_mark = pop_total;
        drive_reads(q, 0, stalls, sent);
        check("burst_sent", sent, 8);
        check("burst_stalls", stalls, 0);
        drain("burst");
        check("burst_pops", pop_total - pop_mark, 8);
        check("burst_first_latency", first_pop_cyc - first_acc_cyc, LAT + 1);
        check("burst_span", last_pop_cyc - first_pop_cyc, 7);
        $display("burst: 8 reads, stalls %0d, first response after %0d cycles",
                 stalls, first_pop_cyc - first_acc_cyc);

        // Backpressure: credits run out, a single pop frees exactly one slot
        s_axil_rready = 1'b0;
        acc_n = 0;
        @(posedge clk); #1;
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = 32'h40;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s_axil_arready) acc_n++;
            @(posedge clk); #1;
            s_axil_araddr = 32'h40 + 32'(acc_n * 4);
        end
        check("bp_accepts", acc_n, DEPTH);
        s_axil_rready = 1'b1;
        @(negedge clk);
        check("bp_arready_full", s_axil_arready, 0);
        @(posedge clk); #1;
        s_axil_rready = 1'b0;
        @(negedge clk);
        check("bp_arready_after_pop", s_axil_arready, 1);
        if (s_axil_arready) acc_n++;
        @(posedge clk); #1;
        s_axil_araddr = 32'h40 + 32'(acc_n * 4);
        @(negedge clk);
        check("bp_arready_refull", s_axil_arready, 0);
        @(posedge clk); #1;
        s_axil_arvalid = 1'b0;
        check("bp_total", acc_n, DEPTH + 1);
        $display("backpressure: %0d accepts", acc_n);
        drain("bp");

        // Misaligned and error reads interleaved with OKAY reads
        fail_addr = 32'h8;
        q.delete();
        q.push_back(32'h0); q.push_back(32'h6); q.push_back(32'h4);
        q.push_back(32'h8); q.push_back(32'hC); q.push_back(32'h3);
        drive_reads(q, 0, stalls, sent);
        check("mix_sent", sent, 6);
        drain("mix");

        // Random traffic with random rready
        q.delete();
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 15);
            q.push_back(32'(r * 4) + ((r % 5 == 0) ? 32'd2 : 32'd0));
        end
        drive_reads(q, 1, stalls, sent);
        check("rand_sent", sent, 24);
        drain("rand");
        $display("random: %0d reads, %0d stalls", sent, stalls);
        fail_addr = 32'hFFFF_FFFF;

        // Reset with three reads outstanding and rvalid high
        q.delete();
        q.push_back(32'h100); q.push_back(32'h104); q.push_back(32'h108);
        drive_reads(q, 2, stalls, sent);
        check("rst_mid_sent", sent, 3);
        for (int c = 0; c < 10 && !s_axil_rvalid; c++) @(posedge clk);
        @(negedge clk);
        check("rst_mid_rvalid_before", s_axil_rvalid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", s_axil_rvalid, 0);
        check("rst_mid_arready", s_axil_arready, 0);
        check("rst_mid_rdata", s_axil_rdata, 0);
        check("rst_mid_rresp", s_axil_rresp, 0);
        check("rst_mid_reg_rd_en", reg_rd_en, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s_axil_rready = 1'b1;
        @(negedge clk);
        check("rst_mid_release_arready", s_axil_arready, 1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("rst_mid_no_stale", s_axil_rvalid, 0);
        end
        $display("reset mid-operation: 3 outstanding reads discarded");

        // Life after reset: one more read works
        q.delete();
        q.push_back(32'h20);
        drive_reads(q, 0, stalls, sent);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
